// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline encodings and the forwarding-select helper
package pipe_hazard_ctrl_pkg;
  localparam int MD_CYCLES_DEF = 8;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EALU = 2'b01, FWD_MALU = 2'b10, FWD_MMEM = 2'b11} fwd_e;
  typedef enum logic {RUN = 1'b0, MDBUSY = 1'b1} md_state_e;
  function automatic fwd_e fwd_sel(input logic [4:0] src, input logic [4:0] e_gpr, input logic [4:0] m_gpr,
                                   input logic e_wreg, input logic e_m2reg, input logic m_wreg, input logic m_m2reg);
    return (src == 5'd0) ? FWD_RF :
           (e_wreg && !e_m2reg && e_gpr == src) ? FWD_EALU :
           (m_wreg && m_gpr == src) ? (m_m2reg ? FWD_MMEM : FWD_MALU) : FWD_RF;
  endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_md_scoreboard.sv
// md_scoreboard: tracks mul/div occupancy and flags the cycle its result becomes valid
module md_scoreboard import pipe_hazard_ctrl_pkg::*; #(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic md_busy,
  output logic md_done
);
  localparam logic [4:0] LOAD = 5'(MD_CYCLES - 1);
  md_state_e state;
  logic [4:0] md_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      md_cnt <= '0;
    end else if (start && (state == RUN || md_cnt == 5'd0)) begin
      state <= MDBUSY;
      md_cnt <= LOAD;
    end else if (state == MDBUSY) begin
      if (md_cnt == 5'd0) state <= RUN;
      else md_cnt <= md_cnt - 5'd1;
    end
  end
  assign md_busy = state == MDBUSY;
  assign md_done = md_busy && md_cnt == 5'd0;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: forwarding selects, load-use and mul/div stalls, branch flush
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic        d_use_hilo,
  input  logic        d_mdstart,
  input  logic        d_branch_taken,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic [4:0]  e_GPR,
  input  logic        m_wreg,
  input  logic        m_m2reg,
  input  logic [4:0]  m_GPR,
  output logic        pc_wen,
  output logic        fd_wen,
  output logic        de_bubble,
  output logic        fd_flush,
  output logic [1:0]  fwda,
  output logic [1:0]  fwdb,
  output logic        md_busy,
  output logic        md_done,
  output logic [15:0] stall_cnt
);
  logic lu_stall, md_stall, stall;
  always_comb begin
    lu_stall = e_wreg && e_m2reg && e_GPR != 5'd0 &&
               ((d_use_rs && e_GPR == d_rs) || (d_use_rt && e_GPR == d_rt));
    md_stall = md_busy && !md_done && (d_use_hilo || d_mdstart);
    stall = lu_stall || md_stall;
    pc_wen = !stall;
    fd_wen = !stall;
    de_bubble = stall;
    fd_flush = d_branch_taken && !stall;
    fwda = fwd_sel(d_rs, e_GPR, m_GPR, e_wreg, e_m2reg, m_wreg, m_m2reg);
    fwdb = fwd_sel(d_rt, e_GPR, m_GPR, e_wreg, e_m2reg, m_wreg, m_m2reg);
  end
  md_scoreboard #(.MD_CYCLES(MD_CYCLES)) u_md (
    .clk(clk),
    .rst(rst),
    .start(d_mdstart && !stall),
    .md_busy(md_busy),
    .md_done(md_done)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stall_cnt <= '0;
    else if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 0, rst = 0;
  logic [4:0] d_rs, d_rt, e_GPR, m_GPR;
  logic d_use_rs, d_use_rt, d_use_hilo, d_mdstart, d_branch_taken, e_wreg, e_m2reg, m_wreg, m_m2reg;
  logic pc_wen, fd_wen, de_bubble, fd_flush, md_busy, md_done;
  logic [1:0] fwda, fwdb;
  logic [15:0] stall_cnt;
  int checks = 0, errors = 0;
  logic [15:0] exp_sc = 0;
  typedef struct { string tag; logic [9:0] v; } exp_t;
  exp_t sb[$];

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_use_hilo(d_use_hilo), .d_mdstart(d_mdstart), .d_branch_taken(d_branch_taken),
    .e_wreg(e_wreg), .e_m2reg(e_m2reg), .e_GPR(e_GPR), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_GPR(m_GPR),
    .pc_wen(pc_wen), .fd_wen(fd_wen), .de_bubble(de_bubble), .fd_flush(fd_flush),
    .fwda(fwda), .fwdb(fwdb), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] e(input logic s, input logic fl, input logic [1:0] fa, input logic [1:0] fb,
                                   input logic bz, input logic dn);
    return {~s, ~s, s, fl, fa, fb, bz, dn};
  endfunction

  task automatic clr();
    {d_rs, d_rt, e_GPR, m_GPR} = '0;
    {d_use_rs, d_use_rt, d_use_hilo, d_mdstart, d_branch_taken, e_wreg, e_m2reg, m_wreg, m_m2reg} = '0;
  endtask

  task automatic push_exp(input string tag, input logic [9:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] xp);
    checks++;
    assert (obs === xp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, xp);
    end
  endtask

  task automatic settle();
    exp_t x;
    logic [9:0] obs;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      obs = {pc_wen, fd_wen, de_bubble, fd_flush, fwda, fwdb, md_busy, md_done};
      checks++;
      assert (obs === x.v) else begin
        errors++;
        $error("FAIL %s obs=%b exp=%b", x.tag, obs, x.v);
      end
      chk16({x.tag, "_stall_cnt"}, stall_cnt, exp_sc);
      if (x.v[7] && exp_sc != 16'hFFFF) exp_sc++;
    end
  endtask

  task automatic step(input string tag, input logic [9:0] v);
    push_exp(tag, v);
    settle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clr();
    @(negedge clk);
    push_exp("reset", e(0, 0, 0, 0, 0, 0));
    settle();
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    e_wreg = 1; e_m2reg = 1; e_GPR = 5; d_rs = 5; d_use_rs = 1;
    step("lu_stall", e(1, 0, 0, 0, 0, 0));
    clr(); m_wreg = 1; m_m2reg = 1; m_GPR = 5; d_rs = 5; d_use_rs = 1;
    step("lu_fwd_mem", e(0, 0, 3, 0, 0, 0));
    clr(); e_wreg = 1; e_GPR = 3; m_wreg = 1; m_GPR = 3; d_rs = 3; d_rt = 3; d_use_rs = 1; d_use_rt = 1;
    step("fwd_e_wins", e(0, 0, 1, 1, 0, 0));
    e_wreg = 0;
    step("fwd_m_alu", e(0, 0, 2, 2, 0, 0));
    clr(); e_wreg = 1; e_m2reg = 1; d_use_rs = 1;
    step("r0_load", e(0, 0, 0, 0, 0, 0));
    clr(); e_wreg = 1; m_wreg = 1; d_use_rs = 1; d_use_rt = 1;
    step("r0_fwd", e(0, 0, 0, 0, 0, 0));
    clr(); e_wreg = 1; e_m2reg = 1; e_GPR = 7; d_rs = 7; d_rt = 7; d_use_rt = 1;
    step("lu_rt", e(1, 0, 0, 0, 0, 0));
    d_use_rt = 0;
    step("lu_unused", e(0, 0, 0, 0, 0, 0));
    clr(); e_wreg = 1; e_m2reg = 1; e_GPR = 4; d_rs = 4; d_use_rs = 1; d_branch_taken = 1;
    step("br_stalled", e(1, 0, 0, 0, 0, 0));
    clr(); d_branch_taken = 1;
    step("br_flush", e(0, 1, 0, 0, 0, 0));
    clr(); d_mdstart = 1;
    step("md_start", e(0, 0, 0, 0, 0, 0));
    d_mdstart = 0; d_use_hilo = 1;
    for (int i = 1; i <= 7; i++) step("md_stall", e(1, 0, 0, 0, 1, 0));
    step("md_done", e(0, 0, 0, 0, 1, 1));
    step("md_idle", e(0, 0, 0, 0, 0, 0));
    clr(); d_mdstart = 1;
    step("md_start2", e(0, 0, 0, 0, 0, 0));
    d_mdstart = 0; d_use_hilo = 1;
    for (int i = 1; i <= 7; i++) step("md_stall2", e(1, 0, 0, 0, 1, 0));
    d_use_hilo = 0; d_mdstart = 1;
    step("md_restart", e(0, 0, 0, 0, 1, 1));
    d_mdstart = 0;
    for (int i = 1; i <= 7; i++) step("md_busy_free", e(0, 0, 0, 0, 1, 0));
    step("md_done2", e(0, 0, 0, 0, 1, 1));
    step("md_idle2", e(0, 0, 0, 0, 0, 0));
    d_mdstart = 1;
    step("md_start3", e(0, 0, 0, 0, 0, 0));
    d_mdstart = 0;
    step("md_t1", e(0, 0, 0, 0, 1, 0));
    step("md_t2", e(0, 0, 0, 0, 1, 0));
    rst = 0;
    exp_sc = 0;
    push_exp("md_abort", e(0, 0, 0, 0, 0, 0));
    settle();
    @(posedge clk);
    @(negedge clk);
    rst = 1; d_use_hilo = 1;
    for (int i = 0; i < 10; i++) step("no_done", e(0, 0, 0, 0, 0, 0));
    clr();
    rst = 0;
    #1;
    rst = 1;
    e_wreg = 1; e_m2reg = 1; e_GPR = 9; d_rs = 9; d_use_rs = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk16("cnt_3", stall_cnt, 16'd3);
    repeat (65532) @(posedge clk);
    @(negedge clk);
    #1;
    chk16("cnt_max", stall_cnt, 16'hFFFF);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    chk16("cnt_sat", stall_cnt, 16'hFFFF);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: MD_CYCLES, default 8, execute latency in cycles of the multi-cycle mul/div unit; legal range 2..31.
REQ-002 Ports: clk input 1, pipeline clock; all state updates on the rising edge.
REQ-003 Ports: rst input 1, asynchronous, active-low reset.
REQ-004 Ports: d_rs, d_rt input 5 each, source register numbers of the instruction in D.
REQ-005 Ports: d_use_rs, d_use_rt, d_use_hilo input 1 each, D instruction reads rs / rt / the mul-div result.
REQ-006 Ports: d_mdstart input 1, D instruction starts a mul/div; d_branch_taken input 1, D branch resolved taken.
REQ-007 Ports: e_wreg, e_m2reg input 1, e_GPR input 5, destination info of the instruction in E.
REQ-008 Ports: m_wreg, m_m2reg input 1, m_GPR input 5, destination info of the instruction in M.
REQ-009 Ports: pc_wen, fd_wen output 1, PC and IF/ID register write enables.
REQ-010 Ports: de_bubble output 1, forces all ID/EX control bits (wreg, m2reg, wmem, jal, aluimm, shift, aluc) to 0 at the next edge.
REQ-011 Ports: fd_flush output 1, clears IF/ID at the next edge.
REQ-012 Ports: fwda, fwdb output 2, operand select: 00 register file, 01 E ALU result, 10 M ALU result, 11 M memory data.
REQ-013 Ports: md_busy output 1, md_done output 1, stall_cnt output 16.

Function
REQ-014 Register 0 shall never be forwarded or cause a stall.
REQ-015 fwda shall be 01 if e_wreg, !e_m2reg, e_GPR==d_rs; else 11 if m_wreg, m_m2reg, m_GPR==d_rs; else 10 if m_wreg, m_GPR==d_rs; else 00. E match wins over M match. fwdb: same rules on d_rt.
REQ-016 lu_stall shall be 1 when e_wreg, e_m2reg, e_GPR!=0 and ((d_use_rs, e_GPR==d_rs) or (d_use_rt, e_GPR==d_rt)).
REQ-017 FSM states: RUN, MDBUSY; 5-bit down counter md_cnt.
REQ-018 RUN: d_mdstart with no stall shall load md_cnt=MD_CYCLES-1 and enter MDBUSY at the next edge.
REQ-019 MDBUSY: md_cnt decrements each cycle; at md_cnt==0 the block shall pulse md_done for that one cycle and return to RUN.
REQ-020 md_stall shall be 1 in MDBUSY when d_use_hilo or d_mdstart; released in the md_done cycle (result valid then).
REQ-021 stall = lu_stall | md_stall, combinational, same cycle; pc_wen=fd_wen=!stall; de_bubble=stall.
REQ-022 fd_flush = d_branch_taken & !stall; a stalled branch shall not flush.
REQ-023 md_busy shall be 1 exactly while state==MDBUSY.
REQ-024 stall_cnt shall increment by 1 each cycle stall==1 and saturate at 0xFFFF.
REQ-025 d_mdstart coincident with md_done shall not stall and shall reload md_cnt, remaining in MDBUSY.

Reset
REQ-026 While rst==0: state RUN, md_cnt 0, stall_cnt 0, md_busy 0, md_done 0; combinational outputs follow inputs.
REQ-027 Reset asserted mid-mul/div shall abandon the operation immediately; no md_done shall follow.

Structure
REQ-028 Forwarding encodings, state encoding and MD_CYCLES default shall reside in the shared pipeline package.
REQ-029 The mul/div occupancy counter shall be one sub-module, md_scoreboard (state, md_cnt, md_busy, md_done).

Verification
REQ-030 E: lw r5 (e_wreg=1, e_m2reg=1, e_GPR=5); D reads rs=5 -> stall 1 cycle: pc_wen=0, de_bubble=1; next cycle fwda=11.
REQ-031 E: add r3 (e_m2reg=0); M: add r3; D rs=3, rt=3 -> fwda=fwdb=01, no stall; with E removed -> 10.
REQ-032 D rs=0 while e_GPR=0, e_wreg=1, e_m2reg=1 -> fwda=00, no stall.
REQ-033 d_mdstart at cycle t (MD_CYCLES=8); d_use_hilo from t+1 -> stall t+1..t+7, md_done at t+8, pc_wen=1 at t+8.
REQ-034 d_branch_taken=1 with lu_stall=1 -> fd_flush=0; next cycle, no stall -> fd_flush=1.
REQ-035 rst=0 at t+3 of a mul/div -> md_busy=0 immediately, no md_done; stall_cnt counts 0xFFFF+5 stall cycles -> reads 0xFFFF.
